ibuff_fetch_ctrl: RTL

// - Frontend D1 sequencer between the I-cache line fill and the D1 byte rotator.
// - Holds up to two 64-byte lines and tracks the PC byte offset within the head line.
// - Presents a rotator-ready line plus a 6-bit shift for each instruction, then advances the PC by 2 (RVC) or 4.
// - Builds a merged line for 32-bit instructions that straddle two lines; filters stale fills after a resteer.

---
 rtl/frontend_pkg.sv | 29 ++
 rtl/ibuff_line_fifo.sv | 83 ++++++++
 rtl/ibuff_fetch_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/frontend_pkg.sv
// Shared types and constants for the D1 instruction-buffer sequencer.
package frontend_pkg;

    localparam int LINE_BYTES = 64;
    localparam int OFF_W      = 6;
    localparam int LINE_W     = LINE_BYTES * 8;

    // Offset at which a 32-bit instruction spills into the next line.
    localparam logic [OFF_W-1:0] STRADDLE_OFF = OFF_W'(LINE_BYTES - 2);

    typedef enum logic [1:0] {
        FILL      = 2'd0,
        RUN       = 2'd1,
        SPAN_WAIT = 2'd2,
        EXC_HOLD  = 2'd3
    } ibuff_state_t;

    // One buffered fill: the line bytes plus its fetch-fault flag.
    typedef struct packed {
        logic              exc;
        logic [LINE_W-1:0] data;
    } line_entry_t;

    // Low two bits of the first parcel select 16-bit (RVC) or 32-bit encoding.
    function automatic logic is_rvc(input logic [1:0] lo_bits);
        return lo_bits != 2'b11;
    endfunction

endpackage

// File: rtl/ibuff_line_fifo.sv
// Two-entry line buffer. Exposes the head entry and the first two bytes
// of the second entry (all the straddle merge ever needs from it).
// rst is active-low and synchronous; clear_i flushes both slots.
module ibuff_line_fifo
    import frontend_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              push_i,
    input  line_entry_t       push_entry_i,
    input  logic              pop_i,
    output logic [1:0]        count_o,
    output line_entry_t       head_o,
    output logic [15:0]       second_prefix_o
);

    logic        wr_ptr_q;
    logic        wr_ptr_d;
    logic        rd_ptr_q;
    logic        rd_ptr_d;
    logic [1:0]  count_q;
    logic [1:0]  count_d;
    logic        push_ok;
    logic        pop_ok;
    line_entry_t slot_rd [2];

    // Guard against overflow/underflow even if the caller misbehaves.
    assign push_ok = push_i && (count_q != 2'd2);
    assign pop_ok  = pop_i  && (count_q != 2'd0);

    // One storage register per slot; only the slot under the write pointer loads.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            line_entry_t slot_q;

            // Capture the fill into this slot when it is the write target.
            always_ff @(posedge clk) begin
                if (push_ok && (wr_ptr_q == 1'(gi))) begin
                    slot_q <= push_entry_i;
                end
            end

            assign slot_rd[gi] = slot_q;
        end
    endgenerate

    // Pointer and occupancy next-state; simultaneous push+pop keeps count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Pointer/occupancy registers; reset and flush both empty the buffer.
    always_ff @(posedge clk) begin
        if (!rst || clear_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count_o         = count_q;
    assign head_o          = slot_rd[rd_ptr_q];
    assign second_prefix_o = slot_rd[~rd_ptr_q].data[15:0];

endmodule

// File: rtl/ibuff_fetch_ctrl.sv
// D1 fetch sequencer: buffers up to two I-cache lines, walks the PC through
// the head line, and presents a rotator-ready line plus byte shift per
// instruction. Handles line-straddling 32-bit instructions, fetch faults,
// misaligned PCs and resteers (which also filter stale in-flight fills).
module ibuff_fetch_ctrl
    import frontend_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              resteer,
    input  logic [XLEN-1:0]   resteer_target,
    input  logic              line_valid,
    output logic              line_ready,
    input  logic [XLEN-1:0]   line_addr,
    input  logic [LINE_W-1:0] line_data,
    input  logic              line_exc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [LINE_W-1:0] rot_line,
    output logic [OFF_W-1:0]  rot_shift,
    output logic [XLEN-1:0]   pc,
    output logic              compressed,
    output logic              exception_out
);

    ibuff_state_t      state_q;
    ibuff_state_t      state_d;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   pc_d;
    logic [XLEN-1:0]   expect_q;
    logic [XLEN-1:0]   expect_d;

    logic [1:0]        fifo_count;
    line_entry_t       head;
    logic [15:0]       second_prefix;
    line_entry_t       push_entry;

    logic [OFF_W-1:0]  off;
    logic              head_valid;
    logic              second_valid;
    logic              head_rvc;
    logic              exc_cond;
    logic              straddle;
    logic              span_pending;
    logic              push;
    logic              pop;
    logic              fire;
    logic              advance;
    logic [XLEN-1:0]   inst_len;
    logic [OFF_W:0]    end_sum;
    logic [LINE_W-1:0] merged_line;

    // Aligns an address down to its line base.
    function automatic logic [XLEN-1:0] line_base(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
    endfunction

    // ------------------------------------------------------------------
    // Line buffer
    // ------------------------------------------------------------------
    assign push_entry = '{exc: line_exc, data: line_data};

    ibuff_line_fifo u_fifo (
        .clk             (clk),
        .rst             (rst),
        .clear_i         (resteer),
        .push_i          (push),
        .push_entry_i    (push_entry),
        .pop_i           (pop),
        .count_o         (fifo_count),
        .head_o          (head),
        .second_prefix_o (second_prefix)
    );

    // ------------------------------------------------------------------
    // Decode of the current window
    // ------------------------------------------------------------------
    assign off          = pc_q[OFF_W-1:0];
    assign head_valid   = (fifo_count != 2'd0);
    assign second_valid = (fifo_count == 2'd2);
    assign head_rvc     = is_rvc(head.data[{off, 3'b000} +: 2]);

    // A faulting line or an odd PC turns the window into an exception report.
    assign exc_cond     = head_valid && (head.exc || pc_q[0]);

    // A 32-bit instruction at the last parcel needs bytes 0..1 of the next line.
    assign straddle     = (off == STRADDLE_OFF) && !head_rvc;
    assign span_pending = straddle && !second_valid;

    // Head bytes 0..1 are never part of a straddling instruction, so they are
    // overwritten with the next line's first parcel; the rotator wraps mod 64.
    assign merged_line  = {head.data[LINE_W-1:16], second_prefix};

    // ------------------------------------------------------------------
    // Fill acceptance and instruction advance
    // ------------------------------------------------------------------
    assign line_ready = (fifo_count != 2'd2);

    // Fills for any address other than the expected one are stale; drop them.
    assign push = line_valid && line_ready && (line_addr == expect_q) && !resteer;

    assign fire     = inst_valid && inst_ready;
    assign advance  = (state_q == RUN) && fire && !exc_cond && !resteer;
    assign inst_len = head_rvc ? XLEN'(2) : XLEN'(4);

    // Carry out of offset+length means the instruction consumed the head line.
    assign end_sum  = {1'b0, off} + (OFF_W + 1)'(head_rvc ? 2 : 4);
    assign pop      = advance && end_sum[OFF_W];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: resteer dominates; otherwise track buffer occupancy and faults.
    always_comb begin
        state_d = state_q;
        if (resteer) begin
            state_d = FILL;
        end else begin
            case (state_q)
                FILL: begin
                    if (head_valid || push) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (exc_cond) begin
                        state_d = EXC_HOLD;
                    end else if (pop && (fifo_count == 2'd1) && !push) begin
                        state_d = FILL;
                    end else if (span_pending && !push) begin
                        state_d = SPAN_WAIT;
                    end
                end
                SPAN_WAIT: begin
                    if (push) begin
                        state_d = RUN;
                    end
                end
                EXC_HOLD: begin
                    state_d = EXC_HOLD;
                end
                default: begin
                    state_d = FILL;
                end
            endcase
        end
    end

    // Outputs: window validity from state, line/shift/compressed only when valid.
    always_comb begin
        inst_valid    = 1'b0;
        exception_out = 1'b0;
        rot_line      = '0;
        rot_shift     = '0;
        compressed    = 1'b0;
        case (state_q)
            RUN: begin
                if (exc_cond) begin
                    inst_valid    = 1'b1;
                    exception_out = 1'b1;
                end else begin
                    inst_valid    = !span_pending;
                end
            end
            EXC_HOLD: begin
                inst_valid    = 1'b1;
                exception_out = 1'b1;
            end
            default: begin
                inst_valid    = 1'b0;
            end
        endcase
        if (inst_valid) begin
            rot_line   = (straddle && second_valid) ? merged_line : head.data;
            rot_shift  = off;
            compressed = head_rvc;
        end
    end

    // ------------------------------------------------------------------
    // PC and expected-fill-address registers
    // ------------------------------------------------------------------

    // PC moves on resteer or on an accepted non-faulting instruction;
    // the expected fill address steps one line per accepted fill.
    always_comb begin
        pc_d     = pc_q;
        expect_d = expect_q;
        if (resteer) begin
            pc_d     = resteer_target;
            expect_d = line_base(resteer_target);
        end else begin
            if (advance) begin
                pc_d = pc_q + inst_len;
            end
            if (push) begin
                expect_d = expect_q + XLEN'(LINE_BYTES);
            end
        end
    end

    // PC / expected-address storage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q     <= RESET_PC;
            expect_q <= line_base(RESET_PC);
        end else begin
            pc_q     <= pc_d;
            expect_q <= expect_d;
        end
    end

    assign pc = pc_q;

endmodule
